// File: rtl/dmem_ctrl_pkg.sv
// Shared types and constants for the MEM-stage data-memory controller.
// Used by dmem_ctrl, dmem_lane_align and dmem_ctrl_if.
package dmem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // funct3[1:0] gives the access width for both loads and stores.
  function automatic logic [1:0] size_of(input logic [1:0] width);
    case (width)
      2'b00:   return SIZE_BYTE;
      2'b01:   return SIZE_HALF;
      default: return SIZE_WORD;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Pipeline-side request/response bundle of dmem_ctrl.
// master = EX/MEM + MEM/WB side, slave = the controller.
interface dmem_ctrl_if;
  import dmem_ctrl_pkg::*;

  // Handshake: a request is taken on a clock edge where req_valid=1 while the
  // controller is idle; stall holds the pipeline until the one-cycle
  // resp_valid strobe, and resp_err/resp_rdata are meaningful with resp_valid.
  logic        req_valid;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  state_t      state_dbg;

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata,
    input  stall, resp_valid, resp_rdata, resp_err, state_dbg
  );

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata,
    output stall, resp_valid, resp_rdata, resp_err, state_dbg
  );

endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for stores, extraction/extension for loads, and
// misalignment / illegal-funct3 detection. Purely combinational.
module dmem_lane_align
  import dmem_ctrl_pkg::*;
(
  input  logic        write,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] bus_rdata,
  output logic [31:0] wdata_lanes,
  output logic [31:0] rdata_ext,
  output logic        misaligned,
  output logic        illegal
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = bus_rdata[{addr_lo, 3'b000} +: 8];
    sel_half = addr_lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];

    case (funct3)
      F3_B:    rdata_ext = {{24{sel_byte[7]}}, sel_byte};
      F3_BU:   rdata_ext = {24'h0, sel_byte};
      F3_H:    rdata_ext = {{16{sel_half[15]}}, sel_half};
      F3_HU:   rdata_ext = {16'h0, sel_half};
      F3_W:    rdata_ext = bus_rdata;
      default: rdata_ext = 32'h0;
    endcase

    // Narrow stores are replicated so the memory can pick any lane.
    case (funct3[1:0])
      2'b00:   wdata_lanes = {4{wdata[7:0]}};
      2'b01:   wdata_lanes = {2{wdata[15:0]}};
      default: wdata_lanes = wdata;
    endcase

    if (write) begin
      illegal = funct3[2] | (funct3[1:0] == 2'b11);
    end else begin
      illegal = (funct3 == 3'b011) | (funct3 == 3'b110) | (funct3 == 3'b111);
    end

    misaligned = ((funct3[1:0] == 2'b01) & addr_lo[0]) |
                 ((funct3[1:0] == 2'b10) & (addr_lo != 2'b00));
  end

endmodule

// File: rtl/dmem_ctrl.sv
// MEM-stage load/store sequencer for the shared DAD/DDT/MREQ/WRITE/SIZE/ACKD_n bus.
// Optional bus timeout is compiled in with `define DMEM_TIMEOUT_EN.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  dmem_ctrl_if.slave  pipe,
  output logic [31:0] DAD,
  inout  wire  [31:0] DDT,
  output logic        MREQ,
  output logic        WRITE,
  output logic [1:0]  SIZE,
  input  logic        ACKD_n
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("dmem_ctrl: TIMEOUT_CYCLES must be at least 1");
  end

  state_t      state_q, state_d;
  logic        write_q, write_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        resp_valid_q, resp_valid_d;
  logic        mreq_q, mreq_d;
  logic        wr_out_q, wr_out_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] dad_q, dad_d;
  logic        ddt_oe_q, ddt_oe_d;

  logic        idle;
  logic        la_write;
  logic [2:0]  la_funct3;
  logic [1:0]  la_addr_lo;
  logic [31:0] la_wdata_lanes;
  logic [31:0] la_rdata_ext;
  logic        la_misaligned;
  logic        la_illegal;
  logic        timeout_hit;

  assign idle = (state_q == ST_IDLE);

  // In IDLE the aligner screens the incoming request; afterwards it decodes the latched one.
  assign la_write   = idle ? pipe.req_write       : write_q;
  assign la_funct3  = idle ? pipe.req_funct3      : funct3_q;
  assign la_addr_lo = idle ? pipe.req_addr[1:0]   : addr_q[1:0];

  dmem_lane_align u_lane_align (
    .write       (la_write),
    .funct3      (la_funct3),
    .addr_lo     (la_addr_lo),
    .wdata       (pipe.req_wdata),
    .bus_rdata   (DDT),
    .wdata_lanes (la_wdata_lanes),
    .rdata_ext   (la_rdata_ext),
    .misaligned  (la_misaligned),
    .illegal     (la_illegal)
  );

`ifdef DMEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_IDLE) begin
      cnt_d = '0;
    end else if ((state_q == ST_ACCESS) && ACKD_n) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // This wait cycle would be the TIMEOUT_CYCLES-th without an acknowledge.
  assign timeout_hit = (state_q == ST_ACCESS) && ACKD_n && (cnt_q == CNT_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;

    case (state_q)
      ST_IDLE: begin
        if (pipe.req_valid) begin
          write_d  = pipe.req_write;
          funct3_d = pipe.req_funct3;
          addr_d   = pipe.req_addr;
          wdata_d  = la_wdata_lanes;
          if (la_misaligned || la_illegal) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
            rdata_d = 32'h0;
          end else begin
            state_d = ST_ACCESS;
            err_d   = 1'b0;
          end
        end
      end
      ST_ACCESS: begin
        if (!ACKD_n) begin
          state_d = ST_DONE;
          err_d   = 1'b0;
          rdata_d = write_q ? 32'h0 : la_rdata_ext;
        end else if (timeout_hit) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
          rdata_d = 32'h0;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Bus and response outputs are registered from the state being entered.
    mreq_d       = (state_d == ST_ACCESS);
    wr_out_d     = mreq_d & write_d;
    ddt_oe_d     = mreq_d & write_d;
    size_d       = mreq_d ? size_of(funct3_d[1:0]) : 2'b00;
    dad_d        = mreq_d ? addr_d : 32'h0;
    resp_valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      write_q      <= 1'b0;
      funct3_q     <= 3'b000;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      rdata_q      <= 32'h0;
      err_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      mreq_q       <= 1'b0;
      wr_out_q     <= 1'b0;
      size_q       <= 2'b00;
      dad_q        <= 32'h0;
      ddt_oe_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      resp_valid_q <= resp_valid_d;
      mreq_q       <= mreq_d;
      wr_out_q     <= wr_out_d;
      size_q       <= size_d;
      dad_q        <= dad_d;
      ddt_oe_q     <= ddt_oe_d;
    end
  end

  assign DDT   = ddt_oe_q ? wdata_q : 32'hzzzz_zzzz;
  assign DAD   = dad_q;
  assign MREQ  = mreq_q;
  assign WRITE = wr_out_q;
  assign SIZE  = size_q;

  assign pipe.stall      = idle ? pipe.req_valid : (state_q == ST_ACCESS);
  assign pipe.resp_valid = resp_valid_q;
  assign pipe.resp_rdata = rdata_q;
  assign pipe.resp_err   = resp_valid_q & err_q;
  assign pipe.state_dbg  = state_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: loads, stores, errors, reset abort and bus timeout.
module tb_dmem_ctrl;
  import dmem_ctrl_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] dad;
  wire  [31:0] ddt;
  logic        mreq;
  logic        wr;
  logic [1:0]  size;
  logic        ack_n;
  logic        mem_oe;
  logic [31:0] mem_drv;

  int errors = 0;
  int checks = 0;

  dmem_ctrl_if pipe ();

  assign ddt = mem_oe ? mem_drv : 32'hzzzz_zzzz;

  dmem_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .pipe   (pipe.slave),
    .DAD    (dad),
    .DDT    (ddt),
    .MREQ   (mreq),
    .WRITE  (wr),
    .SIZE   (size),
    .ACKD_n (ack_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one request from IDLE; returns at posedge+1 with the FSM back in IDLE.
  task automatic run_access(input logic w, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rd, input int waits,
                            input int max_cyc,
                            output logic [31:0] rdata, output logic err, output int lat,
                            output int mreq_cyc, output int stall_cyc, output logic [1:0] size_s,
                            output logic wr_s, output logic [31:0] ddt_s, output logic [31:0] dad_s);
    logic got;
    got = 1'b0; lat = -1; mreq_cyc = 0; stall_cyc = 0;
    rdata = 32'h0; err = 1'b0; size_s = 2'b11; wr_s = 1'b0; ddt_s = 32'h0; dad_s = 32'h0;
    pipe.req_valid = 1'b1; pipe.req_write = w; pipe.req_funct3 = f3;
    pipe.req_addr = addr; pipe.req_wdata = wdata;
    mem_drv = rd; mem_oe = ~w; ack_n = 1'b1;
    #1;
    if (pipe.stall) stall_cyc++;
    for (int c = 1; c <= max_cyc && !got; c++) begin
      @(posedge clk); #1;
      pipe.req_valid = 1'b0;
      if (mreq) begin
        mreq_cyc++;
        size_s = size; wr_s = wr; ddt_s = ddt; dad_s = dad;
        ack_n = (mreq_cyc <= waits);
      end
      if (pipe.stall) stall_cyc++;
      if (pipe.resp_valid) begin
        got = 1'b1; lat = c; rdata = pipe.resp_rdata; err = pipe.resp_err;
      end
    end
    if (got) begin
      @(posedge clk); #1;
    end
    mem_oe = 1'b0; ack_n = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1; pipe.req_valid = 1'b0; pipe.req_write = 1'b0; pipe.req_funct3 = 3'b000;
    pipe.req_addr = 32'h0; pipe.req_wdata = 32'h0; ack_n = 1'b1; mem_oe = 1'b0; mem_drv = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (mreq !== 1'b0) begin errors++; $display("FAIL reset_mreq: got %b want 0", mreq); end
    checks++; if (dad !== 32'h0) begin errors++; $display("FAIL reset_dad: got %h want 0", dad); end
    checks++; if (size !== 2'b00) begin errors++; $display("FAIL reset_size: got %b want 00", size); end
    checks++; if (wr !== 1'b0) begin errors++; $display("FAIL reset_write: got %b want 0", wr); end
    checks++; if (pipe.stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", pipe.stall); end
    checks++; if (pipe.resp_valid !== 1'b0 || pipe.resp_err !== 1'b0 || pipe.resp_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_resp: got v=%b e=%b d=%h want 0/0/0", pipe.resp_valid, pipe.resp_err, pipe.resp_rdata); end
    checks++; if (pipe.state_dbg !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d want 0", pipe.state_dbg); end
    // If the DUT released DDT, the bench pattern reads back unchanged.
    mem_drv = 32'hA5A5_A5A5; mem_oe = 1'b1; #1;
    checks++; if (ddt !== 32'hA5A5_A5A5) begin errors++; $display("FAIL reset_ddt_release: got %h want a5a5a5a5", ddt); end
    mem_oe = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_lw;
    logic [31:0] rd, ds, as; logic e, ws; int lat, mc, sc; logic [1:0] sz;
    run_access(1'b0, F3_W, 32'h0001_0008, 32'h0, 32'hDEAD_BEEF, 0, 20, rd, e, lat, mc, sc, sz, ws, ds, as);
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_rdata: got %h want deadbeef", rd); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL lw_err: got %b want 0", e); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL lw_latency: got %0d want 2", lat); end
    checks++; if (mc !== 1) begin errors++; $display("FAIL lw_mreq_cycles: got %0d want 1", mc); end
    checks++; if (sc !== 2) begin errors++; $display("FAIL lw_stall_cycles: got %0d want 2", sc); end
    checks++; if (sz !== SIZE_WORD || ws !== 1'b0) begin errors++; $display("FAIL lw_size_write: got %b/%b want 00/0", sz, ws); end
    checks++; if (as !== 32'h0001_0008) begin errors++; $display("FAIL lw_dad: got %h want 00010008", as); end
    checks++; if (mreq !== 1'b0 || pipe.resp_valid !== 1'b0) begin errors++; $display("FAIL lw_idle_after: got mreq=%b v=%b want 0/0", mreq, pipe.resp_valid); end
    checks++; if (pipe.resp_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_rdata_hold: got %h want deadbeef", pipe.resp_rdata); end
  endtask

  task automatic test_load_ext;
    logic [31:0] rd, ds, as; logic e, ws; int lat, mc, sc; logic [1:0] sz;
    run_access(1'b0, F3_B, 32'h0001_0003, 32'h0, 32'h8000_0000, 0, 20, rd, e, lat, mc, sc, sz, ws, ds, as);
    checks++; if (rd !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_sext: got %h want ffffff80", rd); end
    checks++; if (sz !== SIZE_BYTE) begin errors++; $display("FAIL lb_size: got %b want 10", sz); end
    run_access(1'b0, F3_BU, 32'h0001_0003, 32'h0, 32'h8000_0000, 0, 20, rd, e, lat, mc, sc, sz, ws, ds, as);
    checks++; if (rd !== 32'h0000_0080) begin errors++; $display("FAIL lbu_zext: got %h want 00000080", rd); end
    run_access(1'b0, F3_HU, 32'h0001_0002, 32'h0, 32'hABCD_0000, 0, 20, rd, e, lat, mc, sc, sz, ws, ds, as);
    checks++; if (rd !== 32'h0000_ABCD) begin errors++; $display("FAIL lhu_zext: got %h want 0000abcd", rd); end
    checks++; if (sz !== SIZE_HALF) begin errors++; $display("FAIL lhu_size: got %b want 01", sz); end
    run_access(1'b0, F3_H, 32'h0001_0000, 32'h0, 32'h1234_9001, 0, 20, rd, e, lat, mc, sc, sz, ws, ds, as);
    checks++; if (rd !== 32'hFFFF_9001) begin errors++; $display("FAIL lh_sext_low: got %h want ffff9001", rd); end
    run_access(1'b0, F3_B, 32'h0001_0001, 32'h0, 32'h0000_7F00, 0, 20, rd, e, lat, mc, sc, sz, ws, ds, as);
    checks++; if (rd !== 32'h0000_007F) begin errors++; $display("FAIL lb_pos_lane1: got %h want 0000007f", rd); end
  endtask

  task automatic test_store;
    logic [31:0] rd, ds, as; logic e, ws; int lat, mc, sc; logic [1:0] sz;
    run_access(1'b1, F3_H, 32'h0001_0002, 32'h1234_5678, 32'h0, 3, 20, rd, e, lat, mc, sc, sz, ws, ds, as);
    checks++; if (ds !== 32'h5678_5678) begin errors++; $display("FAIL sh_ddt: got %h want 56785678", ds); end
    checks++; if (ws !== 1'b1 || sz !== SIZE_HALF) begin errors++; $display("FAIL sh_write_size: got %b/%b want 1/01", ws, sz); end
    checks++; if (mc !== 4) begin errors++; $display("FAIL sh_mreq_cycles: got %0d want 4", mc); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL sh_latency: got %0d want 5", lat); end
    checks++; if (rd !== 32'h0 || e !== 1'b0) begin errors++; $display("FAIL sh_resp: got %h/%b want 0/0", rd, e); end
    run_access(1'b1, F3_B, 32'h0001_0001, 32'h0000_00AB, 32'h0, 1, 20, rd, e, lat, mc, sc, sz, ws, ds, as);
    checks++; if (ds !== 32'hABAB_ABAB || sz !== SIZE_BYTE) begin errors++; $display("FAIL sb_ddt_size: got %h/%b want abababab/10", ds, sz); end
    run_access(1'b1, F3_W, 32'h0001_0004, 32'hCAFE_F00D, 32'h0, 0, 20, rd, e, lat, mc, sc, sz, ws, ds, as);
    checks++; if (ds !== 32'hCAFE_F00D || as !== 32'h0001_0004) begin errors++; $display("FAIL sw_ddt_dad: got %h/%h want cafef00d/00010004", ds, as); end
  endtask

  task automatic test_errors;
    logic [31:0] rd, ds, as; logic e, ws; int lat, mc, sc; logic [1:0] sz;
    run_access(1'b0, F3_W, 32'h0001_0002, 32'h0, 32'h1111_1111, 0, 20, rd, e, lat, mc, sc, sz, ws, ds, as);
    checks++; if (e !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL lw_misalign_resp: got err=%b d=%h want 1/0", e, rd); end
    checks++; if (mc !== 0 || lat !== 1) begin errors++; $display("FAIL lw_misalign_bus: got mreq_cyc=%0d lat=%0d want 0/1", mc, lat); end
    run_access(1'b1, 3'b011, 32'h0001_0000, 32'h5555_5555, 32'h0, 0, 20, rd, e, lat, mc, sc, sz, ws, ds, as);
    checks++; if (e !== 1'b1 || mc !== 0 || lat !== 1) begin errors++; $display("FAIL st_illegal: got err=%b mreq_cyc=%0d lat=%0d want 1/0/1", e, mc, lat); end
    run_access(1'b0, F3_H, 32'h0001_0001, 32'h0, 32'h0, 0, 20, rd, e, lat, mc, sc, sz, ws, ds, as);
    checks++; if (e !== 1'b1 || mc !== 0) begin errors++; $display("FAIL lh_misalign: got err=%b mreq_cyc=%0d want 1/0", e, mc); end
    run_access(1'b0, 3'b110, 32'h0001_0000, 32'h0, 32'h0, 0, 20, rd, e, lat, mc, sc, sz, ws, ds, as);
    checks++; if (e !== 1'b1 || mc !== 0) begin errors++; $display("FAIL ld_illegal: got err=%b mreq_cyc=%0d want 1/0", e, mc); end
  endtask

  task automatic test_back_to_back;
    pipe.req_valid = 1'b1; pipe.req_write = 1'b0; pipe.req_funct3 = F3_W;
    pipe.req_addr = 32'h0000_0100; mem_oe = 1'b1; mem_drv = 32'h1122_3344; ack_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (pipe.resp_valid !== 1'b1 || pipe.resp_rdata !== 32'h1122_3344) begin
      errors++; $display("FAIL b2b_first: got v=%b d=%h want 1/11223344", pipe.resp_valid, pipe.resp_rdata); end
    // req_valid stays high through DONE; it must only be taken once back in IDLE.
    @(posedge clk); #1;
    checks++; if (mreq !== 1'b0 || pipe.state_dbg !== ST_IDLE || pipe.stall !== 1'b1) begin
      errors++; $display("FAIL b2b_done_ignore: got mreq=%b st=%0d stall=%b want 0/0/1", mreq, pipe.state_dbg, pipe.stall); end
    mem_drv = 32'h5566_7788;
    @(posedge clk); #1;
    pipe.req_valid = 1'b0;
    checks++; if (mreq !== 1'b1) begin errors++; $display("FAIL b2b_second_accept: got %b want 1", mreq); end
    @(posedge clk); #1;
    checks++; if (pipe.resp_valid !== 1'b1 || pipe.resp_rdata !== 32'h5566_7788) begin
      errors++; $display("FAIL b2b_second: got v=%b d=%h want 1/55667788", pipe.resp_valid, pipe.resp_rdata); end
    @(posedge clk); #1;
    mem_oe = 1'b0; ack_n = 1'b1;
  endtask

  task automatic test_reset_mid_access;
    logic [31:0] rd, ds, as; logic e, ws; int lat, mc, sc, seen; logic [1:0] sz;
    pipe.req_valid = 1'b1; pipe.req_write = 1'b1; pipe.req_funct3 = F3_W;
    pipe.req_addr = 32'h0001_0010; pipe.req_wdata = 32'h0BAD_F00D; ack_n = 1'b1;
    @(posedge clk); #1;
    pipe.req_valid = 1'b0;
    checks++; if (mreq !== 1'b1 || ddt !== 32'h0BAD_F00D) begin errors++; $display("FAIL rma_access: got mreq=%b ddt=%h want 1/0badf00d", mreq, ddt); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (mreq !== 1'b0 || pipe.stall !== 1'b0 || pipe.resp_valid !== 1'b0) begin
      errors++; $display("FAIL rma_abort: got mreq=%b stall=%b v=%b want 0/0/0", mreq, pipe.stall, pipe.resp_valid); end
    mem_drv = 32'h5A5A_5A5A; mem_oe = 1'b1; #1;
    checks++; if (ddt !== 32'h5A5A_5A5A) begin errors++; $display("FAIL rma_ddt_release: got %h want 5a5a5a5a", ddt); end
    mem_oe = 1'b0; rst = 1'b0;
    seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (pipe.resp_valid) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rma_no_resp: got %0d strobes want 0", seen); end
    run_access(1'b0, F3_W, 32'h0001_0010, 32'h0, 32'h0F0F_0F0F, 1, 20, rd, e, lat, mc, sc, sz, ws, ds, as);
    checks++; if (rd !== 32'h0F0F_0F0F || e !== 1'b0 || lat !== 3) begin
      errors++; $display("FAIL rma_recover: got d=%h err=%b lat=%0d want 0f0f0f0f/0/3", rd, e, lat); end
  endtask

  task automatic test_timeout;
    logic [31:0] rd, ds, as; logic e, ws; int lat, mc, sc; logic [1:0] sz;
`ifdef DMEM_TIMEOUT_EN
    run_access(1'b0, F3_W, 32'h0001_0020, 32'h0, 32'h7777_7777, 1000, 40, rd, e, lat, mc, sc, sz, ws, ds, as);
    checks++; if (e !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL to_resp: got err=%b d=%h want 1/0", e, rd); end
    checks++; if (mc !== 8 || lat !== 9) begin errors++; $display("FAIL to_cycles: got mreq_cyc=%0d lat=%0d want 8/9", mc, lat); end
    checks++; if (mreq !== 1'b0) begin errors++; $display("FAIL to_mreq_drop: got %b want 0", mreq); end
`else
    run_access(1'b0, F3_W, 32'h0001_0020, 32'h0, 32'h7777_7777, 1000, 100, rd, e, lat, mc, sc, sz, ws, ds, as);
    checks++; if (lat !== -1 || mreq !== 1'b1 || mc !== 100) begin
      errors++; $display("FAIL wait_forever: got lat=%0d mreq=%b mreq_cyc=%0d want -1/1/100", lat, mreq, mc); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (mreq !== 1'b0) begin errors++; $display("FAIL wait_reset_exit: got %b want 0", mreq); end
`endif
  endtask

  initial begin
    test_reset();
    test_lw();
    test_load_ext();
    test_store();
    test_errors();
    test_back_to_back();
    test_reset_mid_access();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- MEM-stage controller that sequences every load/store onto the shared data-memory bus (DAD/DDT/MREQ/WRITE/SIZE/ACKD_n).
- Accepts one request at a time from the EX/MEM pipeline register and stalls the pipeline while the bus is busy.
- Handles byte/half/word lane steering, sign/zero extension and misalignment detection.
- Returns load data to the MEM/WB register with a one-cycle response strobe.

Parameters:
- TIMEOUT_CYCLES, 256, bus wait cycles before a timeout error; used only when the optional feature is compiled in.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous reset, active-high
- req_valid  input  1  EX/MEM holds a load or store
- req_write  input  1  1 = store, 0 = load
- req_funct3  input  3  RV32I funct3 of the load/store
- req_addr  input  32  effective byte address
- req_wdata  input  32  store data (rs2)
- stall  output  1  freeze PC and IF/ID, ID/EX, EX/MEM registers
- resp_valid  output  1  one-cycle strobe: access finished
- resp_rdata  output  32  extended load data; 0 for stores and errors
- resp_err  output  1  misaligned, illegal funct3 or timeout; qualified by resp_valid
- DAD  output  32  data address bus
- DDT  inout  32  data bus
- MREQ  output  1  memory request
- WRITE  output  1  1 = write
- SIZE  output  2  00 word, 01 half, 10 byte
- ACKD_n  input  1  0 = memory ready/complete

Behaviour:
- Reset: synchronous, active-high. All outputs are 0 (DAD=0, SIZE=00, MREQ=0, WRITE=0, stall=0, resp_*=0). DDT is high-Z. State is IDLE.
- Reset asserted mid-access aborts at that edge: MREQ drops and DDT releases the next cycle. No resp_valid is produced.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - stall = req_valid (combinational).
  - On an edge with req_valid=1, latch write/funct3/addr/wdata.
  - Legal request: go to ACCESS.
  - Misaligned request (half with addr[0]=1, or word with addr[1:0]!=0) or illegal funct3 (load {011,110,111}, store other than {000,001,010}): go to DONE with err=1; the bus is never touched.
- ACCESS:
  - MREQ=1, DAD=latched address, WRITE=latched write, SIZE from funct3[1:0].
  - stall=1.
  - DDT is driven only when WRITE=1; otherwise high-Z.
  - An edge sampling ACKD_n=0 completes the access: loads capture DDT, then go to DONE. ACKD_n=1 keeps the FSM in ACCESS indefinitely.
- DONE:
  - resp_valid=1 for exactly one cycle; MREQ=0; stall=0 so the pipeline advances.
  - Next edge: return to IDLE. A req_valid present in the DONE cycle is ignored; the pipeline presents the next request in IDLE.
- Latency: accept edge -> ACCESS; ack edge -> DONE. Minimum 2 cycles from request to resp_valid with zero wait states; each ACKD_n=1 cycle adds one.
- Store lane steering:
  - SB replicates wdata[7:0] on all 4 byte lanes.
  - SH replicates wdata[15:0] on both halves.
  - SW passes wdata through.
- Load extraction (little-endian):
  - Byte lane = addr[1:0]; half lane = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- resp_rdata holds its value until the next DONE. It is 0 for stores and errors.

Optional Feature:
- Macro: DMEM_TIMEOUT_EN.
- Defined: an 8-bit+ counter clears on entry to ACCESS and increments each ACCESS cycle with ACKD_n=1. Reaching TIMEOUT_CYCLES forces DONE with resp_err=1, MREQ=0 and resp_rdata=0.
- Undefined: no counter; ACCESS waits forever.

Decomposition:
- Shared package holds:
  - State encoding (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2).
  - SIZE codes (SIZE_WORD=2'b00, SIZE_HALF=2'b01, SIZE_BYTE=2'b10).
  - Load/store funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
- One natural combinational sub-module, dmem_lane_align, does store replication, load extraction/extension and misalign/illegal detection. The FSM stays in dmem_ctrl.

Test Plan:
- LW addr 0x0001_0008, ACKD_n=0 immediately, DDT=0xDEAD_BEEF -> MREQ=1 for 1 cycle, SIZE=00, resp_valid 2 cycles after request, rdata=0xDEAD_BEEF, stall high for exactly 2 cycles.
- LB addr ..._0003, DDT=0x8000_0000 -> rdata=0xFFFF_FF80; LBU same -> 0x0000_0080; LHU addr ..._0002, DDT=0xABCD_0000 -> 0x0000_ABCD.
- SH addr ..._0002, wdata=0x1234_5678, ACKD_n=1 for 3 cycles then 0 -> DDT=0x5678_5678, WRITE=1, SIZE=01, MREQ held 4 cycles, resp_valid after, rdata=0.
- LW addr ..._0002 -> no MREQ, resp_valid next cycle, resp_err=1; store funct3=011 -> same.
- rst=1 during ACCESS wait -> next cycle MREQ=0, DDT=Z, no resp_valid, stall=0; a following LW completes normally.
- With DMEM_TIMEOUT_EN, TIMEOUT_CYCLES=8, ACKD_n stuck 1 -> resp_err=1 after 8 ACCESS cycles, MREQ drops. Without the macro, still waiting at cycle 100.
